// File: rtl/ysyx_23060072_fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC and issues one imem read at a time.
// Latency: REQ -> WAIT -> HOLD, 3 cycles per instruction at best; HOLD stalls until decode accepts.
module ysyx_23060072_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_en_i,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_valid_o,
  input  logic        imem_req_ready_i,
  output logic [31:0] imem_addr_o,
  input  logic        imem_rsp_valid_i,
  input  logic [31:0] imem_rsp_data_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_pc_o,
  output logic [31:0] out_instr_o
);

  typedef enum logic [1:0] {REQ, WAIT, HOLD} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] buf_pc;
  logic [31:0] buf_instr;
  logic        kill;
  logic        handshake;
  logic [31:0] redir_pc;

  assign redir_pc         = redirect_pc_i & ~32'h3;
  // Reset gating keeps the request low for the whole time rst is high.
  assign imem_req_valid_o = (state == REQ) & fetch_en_i & ~rst;
  assign handshake        = imem_req_valid_o & imem_req_ready_i;
  assign imem_addr_o      = pc;
  assign out_valid_o      = (state == HOLD);
  assign out_pc_o         = buf_pc;
  assign out_instr_o      = buf_instr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= REQ;
      pc        <= RESET_PC;
      kill      <= 1'b0;
      buf_pc    <= 32'h0;
      buf_instr <= 32'h0;
    end else begin
      case (state)
        REQ: begin
          if (redirect_valid_i) pc <= redir_pc;
          // A request accepted alongside a redirect is still outstanding; its response must be dropped.
          if (handshake) begin
            state <= WAIT;
            if (redirect_valid_i) kill <= 1'b1;
          end
        end
        WAIT: begin
          if (imem_rsp_valid_i) begin
            if (kill || redirect_valid_i) begin
              kill  <= 1'b0;
              state <= REQ;
              if (redirect_valid_i) pc <= redir_pc;
            end else begin
              buf_pc    <= pc;
              buf_instr <= imem_rsp_data_i;
              pc        <= pc + PC_STEP;
              state     <= HOLD;
            end
          end else if (redirect_valid_i) begin
            kill <= 1'b1;
            pc   <= redir_pc;
          end
        end
        HOLD: begin
          if (redirect_valid_i) begin
            pc    <= redir_pc;
            state <= REQ;
          end else if (out_ready_i) begin
            state <= REQ;
          end
        end
        default: state <= REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_23060072_fetch_ctrl.sv
// Scoreboard bench for the fetch sequencer with a variable-latency imem responder.
module tb_ysyx_23060072_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_en;
  logic        redir_vld;
  logic [31:0] redir_pc;
  logic        req_vld;
  logic        req_rdy;
  logic [31:0] addr;
  logic        rsp_vld;
  logic [31:0] rsp_dat;
  logic        out_vld;
  logic        out_rdy;
  logic [31:0] out_pc;
  logic [31:0] out_instr;

  int n_checks = 0;
  int n_fail   = 0;
  int lat      = 1;
  int epoch    = 0;

  logic [31:0] exp_addr[$];
  logic [31:0] exp_out_pc[$];
  logic [31:0] exp_out_instr[$];

  ysyx_23060072_fetch_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .fetch_en_i       (fetch_en),
    .redirect_valid_i (redir_vld),
    .redirect_pc_i    (redir_pc),
    .imem_req_valid_o (req_vld),
    .imem_req_ready_i (req_rdy),
    .imem_addr_o      (addr),
    .imem_rsp_valid_i (rsp_vld),
    .imem_rsp_data_i  (rsp_dat),
    .out_valid_o      (out_vld),
    .out_ready_i      (out_rdy),
    .out_pc_o         (out_pc),
    .out_instr_o      (out_instr)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] data_of(input logic [31:0] a);
    if (a == 32'h8000_0000) return 32'h0000_0537;
    if (a == 32'h8000_0008) return 32'hDEAD_BEEF;
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Leaves the caller at a falling edge with out_vld high, or reports a timeout.
  task automatic wait_out(input string tag);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (out_vld) found = 1'b1;
    end
    check_eq({tag, "_timeout"}, {31'h0, found}, 32'h1);
  endtask

  task automatic xfer(input logic [31:0] pc);
    exp_out_pc.push_back(pc);
    exp_out_instr.push_back(data_of(pc));
    cyc();
    out_rdy = 1'b1;
    cyc();
    out_rdy = 1'b0;
  endtask

  // Memory model: one response per accepted request, lat cycles after the handshake.
  initial begin
    logic [31:0] a;
    int          l;
    int          ep;
    rsp_vld = 1'b0;
    rsp_dat = 32'h0;
    forever begin
      @(negedge clk);
      if (!rst && req_vld && req_rdy) begin
        a  = addr;
        l  = lat;
        ep = epoch;
        @(posedge clk);
        for (int i = 1; i < l; i++) @(posedge clk);
        #1;
        if (ep == epoch && !rst) begin
          rsp_vld = 1'b1;
          rsp_dat = data_of(a);
          @(posedge clk);
          #1;
          rsp_vld = 1'b0;
        end
      end
    end
  end

  // Monitor: every request and every taken transfer is matched against the scoreboard.
  always @(negedge clk) begin
    if (!rst && req_vld && req_rdy) begin
      check_eq("req_expected", 32'(exp_addr.size() != 0), 32'h1);
      if (exp_addr.size() != 0) check_eq("req_addr", addr, exp_addr.pop_front());
    end
    if (!rst && out_vld && out_rdy && !redir_vld) begin
      check_eq("out_expected", 32'(exp_out_pc.size() != 0), 32'h1);
      if (exp_out_pc.size() != 0) begin
        check_eq("out_pc", out_pc, exp_out_pc.pop_front());
        check_eq("out_instr", out_instr, exp_out_instr.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no end of test expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst       = 1'b1;
    fetch_en  = 1'b1;
    redir_vld = 1'b0;
    redir_pc  = 32'h0;
    req_rdy   = 1'b1;
    out_rdy   = 1'b0;

    // Reset state
    @(negedge clk);
    check_eq("rst_out_valid", {31'h0, out_vld}, 32'h0);
    check_eq("rst_req_valid", {31'h0, req_vld}, 32'h0);
    check_eq("rst_addr", addr, 32'h8000_0000);
    check_eq("rst_out_pc", out_pc, 32'h0);
    exp_addr.push_back(32'h8000_0000);
    cyc();
    rst = 1'b0;

    // First fetch with 1-cycle memory
    wait_out("s1");
    check_eq("s1_pc", out_pc, 32'h8000_0000);
    check_eq("s1_instr", out_instr, 32'h0000_0537);

    // Decode stalls for 5 cycles: buffer stable, no new request
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("s2_valid", {31'h0, out_vld}, 32'h1);
      check_eq("s2_pc", out_pc, 32'h8000_0000);
      check_eq("s2_instr", out_instr, 32'h0000_0537);
      check_eq("s2_no_req", {31'h0, req_vld}, 32'h0);
    end
    exp_addr.push_back(32'h8000_0004);
    lat = 3;
    xfer(32'h8000_0000);

    // Redirect while the 0x80000008 read is outstanding; its stale data must vanish
    wait_out("s3a");
    exp_addr.push_back(32'h8000_0008);
    xfer(32'h8000_0004);
    exp_addr.push_back(32'h8000_0100);
    cyc();
    redir_vld = 1'b1;
    redir_pc  = 32'h8000_0100;
    cyc();
    redir_vld = 1'b0;
    wait_out("s3b");
    check_eq("s3_pc", out_pc, 32'h8000_0100);
    check_eq("s3_instr", out_instr, data_of(32'h8000_0100));

    // Redirect in HOLD wins over out_ready; low address bits are cleared
    exp_addr.push_back(32'h8000_0200);
    cyc();
    redir_vld = 1'b1;
    redir_pc  = 32'h8000_0203;
    out_rdy   = 1'b1;
    cyc();
    redir_vld = 1'b0;
    out_rdy   = 1'b0;
    @(negedge clk);
    check_eq("s4_drop", {31'h0, out_vld}, 32'h0);
    wait_out("s4");
    check_eq("s4_pc", out_pc, 32'h8000_0200);

    // PC wrap at the top of the address space
    exp_addr.push_back(32'hFFFF_FFFC);
    exp_addr.push_back(32'h0000_0000);
    cyc();
    redir_vld = 1'b1;
    redir_pc  = 32'hFFFF_FFFC;
    cyc();
    redir_vld = 1'b0;
    wait_out("s5");
    check_eq("s5_pc", out_pc, 32'hFFFF_FFFC);
    xfer(32'hFFFF_FFFC);

    // Reset while waiting on the 0x00000000 read
    cyc();
    rst = 1'b1;
    epoch++;
    #1;
    check_eq("s6_out_valid", {31'h0, out_vld}, 32'h0);
    check_eq("s6_req_valid", {31'h0, req_vld}, 32'h0);
    check_eq("s6_addr", addr, 32'h8000_0000);
    exp_addr.push_back(32'h8000_0000);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    lat = 1;
    wait_out("s6");
    check_eq("s6_pc", out_pc, 32'h8000_0000);
    check_eq("s6_instr", out_instr, 32'h0000_0537);
    xfer(32'h8000_0000);

    // fetch_en low blocks new requests in REQ
    fetch_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("fen_block", {31'h0, req_vld}, 32'h0);
    end
    check_eq("addr_queue_empty", 32'(exp_addr.size()), 32'h0);
    check_eq("out_queue_empty", 32'(exp_out_pc.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_23060072_fetch_ctrl.md
Name: ysyx_23060072_fetch_ctrl

Overview:
- Instruction fetch sequencer between the PC and the instruction memory.
- Owns the PC register and issues one instruction read at a time over a valid/ready request channel. Accepts variable-latency responses and buffers the returned instruction in a one-entry skid register for decode.
- Handles redirects (branch/jump/exception) at any point and discards stale in-flight responses. Replaces the fixed-latency combinational fetch path so that wait-state memories can be attached.

Parameters:
- RESET_PC, 32'h8000_0000, PC value loaded on reset.
- PC_STEP, 4, PC increment per fetched instruction.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- fetch_en_i  input  1  enables issuing new requests; does not cancel in-flight ones
- redirect_valid_i  input  1  one-cycle redirect pulse
- redirect_pc_i  input  32  redirect target; bits [1:0] forced to 0 internally
- imem_req_valid_o  output  1  read request valid
- imem_req_ready_i  input  1  memory accepts request (handshake = valid & ready)
- imem_addr_o  output  32  request address (= PC), sampled by memory only at handshake
- imem_rsp_valid_i  input  1  read data valid, exactly one per accepted request, earliest one cycle after handshake
- imem_rsp_data_i  input  32  read data
- out_valid_o  output  1  instruction available to decode
- out_ready_i  input  1  decode accepts (transfer = valid & ready)
- out_pc_o  output  32  PC of buffered instruction
- out_instr_o  output  32  buffered instruction

Behaviour:
- State register: REQ, WAIT, HOLD. Internal regs: pc, kill flag, buf_pc, buf_instr.
- Reset (async, any time):
  - state=REQ, pc=RESET_PC, kill=0, buf_pc=0, buf_instr=0.
  - Outputs: out_valid_o=0, imem_req_valid_o=0 while rst high.
  - Memory shares rst, so no response arrives after reset.
- Output decode:
  - imem_req_valid_o = (state==REQ) & fetch_en_i.
  - imem_addr_o = pc.
  - out_valid_o = (state==HOLD).
  - out_pc_o/out_instr_o = buf regs.
- REQ:
  - redirect & handshake in same cycle: request counts as issued; kill<=1, pc<=redirect_pc, ->WAIT.
  - redirect without handshake: pc<=redirect_pc, stay REQ. The address may change while unacknowledged.
  - handshake without redirect: ->WAIT.
  - imem_rsp_valid_i ignored.
- WAIT:
  - rsp_valid & (kill | redirect_valid_i): discard data, kill<=0, ->REQ. If redirect that cycle, pc<=redirect_pc.
  - rsp_valid & !kill & !redirect: buf_pc<=pc, buf_instr<=rsp_data, pc<=pc+PC_STEP, ->HOLD.
  - redirect without rsp: kill<=1, pc<=redirect_pc, stay WAIT.
- HOLD:
  - redirect (priority over out_ready): buffer dropped, pc<=redirect_pc, ->REQ. Decode sees out_valid_o=1 that cycle, but a transfer coinciding with redirect is defined as not taken; decode gates on redirect.
  - out_ready: transfer, ->REQ.
  - Otherwise hold; buf regs stable while out_valid_o=1.
- Throughput: for 1-cycle memory with ready=1, one instruction per 3 cycles (REQ, WAIT, HOLD).
- Arithmetic: pc+PC_STEP is 32-bit modulo; 32'hFFFF_FFFC wraps to 0.
- fetch_en_i=0 only blocks new requests in REQ. WAIT and HOLD complete normally.
- At most one outstanding request. kill is cleared only by the response it marks.

Test Plan:
- Reset, fetch_en=1, ready=1, rsp one cycle later with data 0x00000537 -> request addr 0x80000000; out_valid high with out_pc=0x80000000, out_instr=0x00000537; next request addr 0x80000004.
- out_ready=0 for 5 cycles in HOLD -> out_valid stays 1, out_pc/out_instr stable, no new imem request. Then ready=1 -> one transfer, next request 0x80000004.
- Redirect to 0x80000100 while in WAIT; stale rsp 0xDEADBEEF arrives -> never appears on out. Next request addr 0x80000100.
- Redirect to 0x80000203 during HOLD -> out_valid drops next cycle. Next request addr 0x80000200 (low bits cleared).
- Redirect to 0xFFFFFFFC, fetch completes -> following request addr 0x00000000 (wrap).
- Assert rst while in WAIT -> out_valid=0 and req_valid=0 immediately. After release, first request addr 0x80000000 with kill cleared.
